// File: rtl/ssd_pkg.sv
// Shared constants for the seven-segment scan driver: nibble width and
// active-low segment patterns in a..g order (bit 0 of a [0:6] vector is a).
package ssd_pkg;

  localparam int NIB_W = 4;

  typedef logic [0:6] seg_t;

  localparam seg_t SEG_0     = 7'b000_0001;
  localparam seg_t SEG_1     = 7'b100_1111;
  localparam seg_t SEG_2     = 7'b001_0010;
  localparam seg_t SEG_3     = 7'b000_0110;
  localparam seg_t SEG_4     = 7'b100_1100;
  localparam seg_t SEG_5     = 7'b010_0100;
  localparam seg_t SEG_6     = 7'b010_0000;
  localparam seg_t SEG_7     = 7'b000_1111;
  localparam seg_t SEG_8     = 7'b000_0000;
  localparam seg_t SEG_9     = 7'b000_0100;
  localparam seg_t SEG_A     = 7'b000_1000;
  localparam seg_t SEG_B     = 7'b110_0000;
  localparam seg_t SEG_C     = 7'b011_0001;
  localparam seg_t SEG_D     = 7'b100_0010;
  localparam seg_t SEG_E     = 7'b011_0000;
  localparam seg_t SEG_F     = 7'b011_1000;
  localparam seg_t SEG_BLANK = 7'b111_1111;

endpackage

// File: rtl/ssd_hex_decode.sv
// Combinational nibble to active-low segment decoder; letters only when
// hex_en is set, otherwise nibbles 10..15 decode to blank.
module ssd_hex_decode
  import ssd_pkg::*;
(
  input  logic [NIB_W-1:0] nib,
  input  logic             hex_en,
  output seg_t             seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (nib)
      4'h0: seg = SEG_0;
      4'h1: seg = SEG_1;
      4'h2: seg = SEG_2;
      4'h3: seg = SEG_3;
      4'h4: seg = SEG_4;
      4'h5: seg = SEG_5;
      4'h6: seg = SEG_6;
      4'h7: seg = SEG_7;
      4'h8: seg = SEG_8;
      4'h9: seg = SEG_9;
      4'hA: seg = hex_en ? SEG_A : SEG_BLANK;
      4'hB: seg = hex_en ? SEG_B : SEG_BLANK;
      4'hC: seg = hex_en ? SEG_C : SEG_BLANK;
      4'hD: seg = hex_en ? SEG_D : SEG_BLANK;
      4'hE: seg = hex_en ? SEG_E : SEG_BLANK;
      4'hF: seg = hex_en ? SEG_F : SEG_BLANK;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/ssd_scan_mux.sv
// Time-multiplexed N-digit seven-segment driver: tear-free frame-boundary
// updates, per-slot anode blanking and optional leading-zero suppression.
module ssd_scan_mux
  import ssd_pkg::*;
#(
  parameter int N_DIGITS  = 8,
  parameter int SLOT_CYC  = 12500,
  parameter int BLANK_CYC = 250,
  parameter bit HEX_EN    = 1'b1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      load,
  input  logic [NIB_W*N_DIGITS-1:0] value,
  input  logic [N_DIGITS-1:0]       dp_in,
  input  logic [N_DIGITS-1:0]       en_in,
  input  logic                      lz_blank,
  output logic [0:6]                seg,
  output logic                      dp,
  output logic [N_DIGITS-1:0]       digit,
  output logic                      frame_start
);

  localparam int SW = $clog2(SLOT_CYC);
  localparam int IW = $clog2(N_DIGITS);
  localparam int VW = NIB_W * N_DIGITS;

  logic [SW-1:0]       slot_cnt;
  logic [IW-1:0]       idx;
  logic                slot_tc;
  logic                frame_wrap;

  logic [VW-1:0]       pend_val;
  logic [N_DIGITS-1:0] pend_dp;
  logic [N_DIGITS-1:0] pend_en;
  logic                pend_lz;
  logic                pend_valid;

  logic [VW-1:0]       disp_val;
  logic [N_DIGITS-1:0] disp_dp;
  logic [N_DIGITS-1:0] disp_en;
  logic                disp_lz;

  logic [NIB_W-1:0]    nibs [N_DIGITS];
  logic [N_DIGITS-1:0] sup;
  logic [NIB_W-1:0]    cur_nib;
  seg_t                dec_seg;

  assign slot_tc    = (slot_cnt == SW'(SLOT_CYC - 1));
  assign frame_wrap = slot_tc && (idx == IW'(N_DIGITS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_cnt    <= '0;
      idx         <= '0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= frame_wrap;
      if (slot_tc) begin
        slot_cnt <= '0;
        idx      <= frame_wrap ? '0 : idx + IW'(1);
      end else begin
        slot_cnt <= slot_cnt + SW'(1);
      end
    end
  end

  // A load landing on the boundary cycle bypasses pending so that frame uses it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_val   <= '0;
      pend_dp    <= '0;
      pend_en    <= '1;
      pend_lz    <= 1'b0;
      pend_valid <= 1'b0;
      disp_val   <= '0;
      disp_dp    <= '0;
      disp_en    <= '1;
      disp_lz    <= 1'b0;
    end else if (frame_wrap) begin
      pend_valid <= 1'b0;
      if (load) begin
        disp_val <= value;
        disp_dp  <= dp_in;
        disp_en  <= en_in;
        disp_lz  <= lz_blank;
      end else if (pend_valid) begin
        disp_val <= pend_val;
        disp_dp  <= pend_dp;
        disp_en  <= pend_en;
        disp_lz  <= pend_lz;
      end
    end else if (load) begin
      pend_val   <= value;
      pend_dp    <= dp_in;
      pend_en    <= en_in;
      pend_lz    <= lz_blank;
      pend_valid <= 1'b1;
    end
  end

  for (genvar k = 0; k < N_DIGITS; k++) begin : g_digit
    assign nibs[k] = disp_val[k*NIB_W +: NIB_W];
    if (k == 0) begin : g_rightmost
      assign sup[k] = 1'b0;
    end else begin : g_upper
      assign sup[k] = disp_lz && (disp_val[VW-1:k*NIB_W] == '0);
    end
  end

  assign cur_nib = nibs[idx];

  ssd_hex_decode u_dec (
    .nib    (cur_nib),
    .hex_en (HEX_EN),
    .seg    (dec_seg)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digit <= '1;
      seg   <= SEG_BLANK;
      dp    <= 1'b1;
    end else if (slot_cnt < SW'(BLANK_CYC)) begin
      digit <= '1;
      seg   <= SEG_BLANK;
      dp    <= 1'b1;
    end else begin
      digit <= ~(N_DIGITS'(1) << idx);
      seg   <= (!disp_en[idx] || sup[idx]) ? SEG_BLANK : dec_seg;
      dp    <= disp_en[idx] ? ~disp_dp[idx] : 1'b1;
    end
  end

endmodule

// File: tb/tb_ssd_scan_mux.sv
// Bench for ssd_scan_mux: a frame-position model checked every cycle against
// hex and non-hex instances, plus directed literal expectations.
module tb_ssd_scan_mux;

  localparam int N     = 4;
  localparam int SLOT  = 20;
  localparam int BLANK = 4;
  localparam int P     = N * SLOT;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            load;
  logic [4*N-1:0]  value;
  logic [N-1:0]    dp_in;
  logic [N-1:0]    en_in;
  logic            lz_blank;

  logic [0:6]      seg_h, seg_n;
  logic            dp_h, dp_n;
  logic [N-1:0]    digit_h, digit_n;
  logic            fs_h, fs_n;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ssd_scan_mux #(.N_DIGITS(N), .SLOT_CYC(SLOT), .BLANK_CYC(BLANK), .HEX_EN(1'b1)) dut_h (
    .clk(clk), .rst_n(rst_n), .load(load), .value(value), .dp_in(dp_in),
    .en_in(en_in), .lz_blank(lz_blank), .seg(seg_h), .dp(dp_h),
    .digit(digit_h), .frame_start(fs_h)
  );

  ssd_scan_mux #(.N_DIGITS(N), .SLOT_CYC(SLOT), .BLANK_CYC(BLANK), .HEX_EN(1'b0)) dut_n (
    .clk(clk), .rst_n(rst_n), .load(load), .value(value), .dp_in(dp_in),
    .en_in(en_in), .lz_blank(lz_blank), .seg(seg_n), .dp(dp_n),
    .digit(digit_n), .frame_start(fs_n)
  );

  localparam logic [0:6] BL = 7'b111_1111;
  logic [0:6] seg_tbl [16] = '{
    7'b000_0001, 7'b100_1111, 7'b001_0010, 7'b000_0110,
    7'b100_1100, 7'b010_0100, 7'b010_0000, 7'b000_1111,
    7'b000_0000, 7'b000_0100, 7'b000_1000, 7'b110_0000,
    7'b011_0001, 7'b100_0010, 7'b011_0000, 7'b011_1000
  };

  function automatic logic [0:6] glyph(input logic [3:0] nib, input bit hex);
    if (nib > 4'd9 && !hex) return BL;
    return seg_tbl[nib];
  endfunction

  // Model: what the pins must show in the cycle after position c of the frame.
  int              t, c, s, o;
  logic [4*N-1:0]  m_val, p_val;
  logic [N-1:0]    m_dp, m_en, p_dp, p_en;
  logic            m_lz, p_lz, p_valid, m_sup;
  logic [3:0]      m_nib;
  logic [N-1:0]    exp_digit;
  logic [0:6]      exp_seg_h, exp_seg_n;
  logic            exp_dp, exp_fs;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      t = 0;
      m_val = '0; m_dp = '0; m_en = '1; m_lz = 1'b0;
      p_val = '0; p_dp = '0; p_en = '1; p_lz = 1'b0; p_valid = 1'b0;
      exp_digit = '1; exp_seg_h = BL; exp_seg_n = BL; exp_dp = 1'b1; exp_fs = 1'b0;
    end else begin
      c = t % P;
      s = c / SLOT;
      o = c % SLOT;
      exp_digit = '1; exp_seg_h = BL; exp_seg_n = BL; exp_dp = 1'b1;
      if (o >= BLANK) begin
        exp_digit = ~(4'b0001 << s);
        m_nib = m_val[4*s +: 4];
        m_sup = m_lz && (s != 0) && ((m_val >> (4*s)) == 0);
        if (m_en[s]) begin
          exp_dp = ~m_dp[s];
          if (!m_sup) begin
            exp_seg_h = glyph(m_nib, 1'b1);
            exp_seg_n = glyph(m_nib, 1'b0);
          end
        end
      end
      exp_fs = (c == P - 1);
      if (c == P - 1) begin
        if (load) begin
          m_val = value; m_dp = dp_in; m_en = en_in; m_lz = lz_blank;
        end else if (p_valid) begin
          m_val = p_val; m_dp = p_dp; m_en = p_en; m_lz = p_lz;
        end
        p_valid = 1'b0;
      end else if (load) begin
        p_val = value; p_dp = dp_in; p_en = en_in; p_lz = lz_blank; p_valid = 1'b1;
      end
      t = t + 1;
    end
  end

  always @(negedge clk) begin
    checks = checks + 1;
    if ({digit_h, seg_h, dp_h, fs_h} !== {exp_digit, exp_seg_h, exp_dp, exp_fs}) begin
      errors = errors + 1;
      $display("FAIL scan_hex t=%0t got digit=%b seg=%b dp=%b fs=%b want digit=%b seg=%b dp=%b fs=%b",
               $time, digit_h, seg_h, dp_h, fs_h, exp_digit, exp_seg_h, exp_dp, exp_fs);
    end
    checks = checks + 1;
    if ({digit_n, seg_n, dp_n, fs_n} !== {exp_digit, exp_seg_n, exp_dp, exp_fs}) begin
      errors = errors + 1;
      $display("FAIL scan_nohex t=%0t got digit=%b seg=%b dp=%b fs=%b want digit=%b seg=%b dp=%b fs=%b",
               $time, digit_n, seg_n, dp_n, fs_n, exp_digit, exp_seg_n, exp_dp, exp_fs);
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks = checks + 1;
    if (got !== want) begin
      errors = errors + 1;
      $display("FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask

  int pos = 0;

  task automatic skip(input int n);
    repeat (n) begin
      @(negedge clk);
      pos = (pos + 1) % P;
    end
  endtask

  task automatic goto_pos(input int p);
    if (p < pos) skip(P - pos);
    skip(p - pos);
  endtask

  task automatic next_frame();
    skip(P - pos);
  endtask

  task automatic do_load(input logic [4*N-1:0] v, input logic [N-1:0] d,
                         input logic [N-1:0] e, input logic l);
    load = 1'b1; value = v; dp_in = d; en_in = e; lz_blank = l;
    skip(1);
    load = 1'b0;
  endtask

  // Pins during the active window of slot s (relative to current frame).
  task automatic check_slot(input string name, input int sl, input logic [N-1:0] dig,
                            input logic [0:6] sh, input logic [0:6] sn, input logic d);
    goto_pos(sl * SLOT + 11);
    chk({name, "_digit"}, 32'(digit_h), 32'(dig));
    chk({name, "_seg_hex"}, 32'(seg_h), 32'(sh));
    chk({name, "_seg_nohex"}, 32'(seg_n), 32'(sn));
    chk({name, "_dp"}, 32'(dp_h), 32'(d));
  endtask

  task automatic sync_fs(input string name, input int want);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!fs_h && n < 200);
    chk(name, 32'(n), 32'(want));
    pos = 0;
  endtask

  initial begin
    rst_n = 1'b0; load = 1'b0; value = '0; dp_in = '0; en_in = '1; lz_blank = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_digit", 32'(digit_h), 32'hF);
    chk("reset_seg", 32'(seg_h), 32'h7F);
    chk("reset_dp", 32'(dp_h), 32'h1);
    chk("reset_fs", 32'(fs_h), 32'h0);
    rst_n = 1'b1;

    sync_fs("first_frame_delay", 80);
    sync_fs("frame_period", 80);
    goto_pos(2);
    chk("blank_window_digit", 32'(digit_h), 32'hF);
    chk("blank_window_seg", 32'(seg_h), 32'h7F);

    goto_pos(5);
    do_load(16'h1234, 4'b0000, 4'hF, 1'b0);
    check_slot("old_value_slot2", 2, 4'b1011, 7'b000_0001, 7'b000_0001, 1'b1);
    check_slot("val1234_slot0", 0, 4'b1110, 7'b100_1100, 7'b100_1100, 1'b1);
    check_slot("val1234_slot3", 3, 4'b0111, 7'b100_1111, 7'b100_1111, 1'b1);

    goto_pos(5);
    do_load(16'h0070, 4'b0000, 4'hF, 1'b1);
    next_frame();
    check_slot("lz70_slot0", 0, 4'b1110, 7'b000_0001, 7'b000_0001, 1'b1);
    check_slot("lz70_slot1", 1, 4'b1101, 7'b000_1111, 7'b000_1111, 1'b1);
    check_slot("lz70_slot2", 2, 4'b1011, BL, BL, 1'b1);
    check_slot("lz70_slot3", 3, 4'b0111, BL, BL, 1'b1);
    goto_pos(5);
    do_load(16'h0000, 4'b0000, 4'hF, 1'b1);
    next_frame();
    check_slot("lz0_slot0", 0, 4'b1110, 7'b000_0001, 7'b000_0001, 1'b1);
    check_slot("lz0_slot1", 1, 4'b1101, BL, BL, 1'b1);

    goto_pos(5);
    do_load(16'hABCF, 4'b0100, 4'hF, 1'b0);
    next_frame();
    check_slot("hex_slot0", 0, 4'b1110, 7'b011_1000, BL, 1'b1);
    check_slot("hex_slot1", 1, 4'b1101, 7'b011_0001, BL, 1'b1);
    goto_pos(2 * SLOT + 2);
    chk("dp_blank_window", 32'(dp_h), 32'h1);
    check_slot("hex_slot2_dp", 2, 4'b1011, 7'b110_0000, BL, 1'b0);
    check_slot("hex_slot3", 3, 4'b0111, 7'b000_1000, BL, 1'b1);

    goto_pos(P - 1);
    do_load(16'h5555, 4'b0000, 4'hF, 1'b0);
    check_slot("boundary_load_slot0", 0, 4'b1110, 7'b010_0100, 7'b010_0100, 1'b1);
    goto_pos(20);
    do_load(16'h1111, 4'b0000, 4'hF, 1'b0);
    goto_pos(40);
    do_load(16'h2222, 4'b0000, 4'b1101, 1'b0);
    check_slot("two_loads_same_frame", 3, 4'b0111, 7'b010_0100, 7'b010_0100, 1'b1);
    next_frame();
    check_slot("two_loads_slot0", 0, 4'b1110, 7'b001_0010, 7'b001_0010, 1'b1);
    check_slot("disabled_slot1", 1, 4'b1101, BL, BL, 1'b1);

    goto_pos(2 * SLOT + 11);
    do_load(16'h9999, 4'b1111, 4'hF, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("midscan_reset_digit", 32'(digit_h), 32'hF);
    chk("midscan_reset_seg", 32'(seg_h), 32'h7F);
    chk("midscan_reset_dp", 32'(dp_h), 32'h1);
    @(negedge clk);
    rst_n = 1'b1;
    sync_fs("restart_frame_delay", 80);
    check_slot("restart_slot0", 0, 4'b1110, 7'b000_0001, 7'b000_0001, 1'b1);
    check_slot("restart_slot3", 3, 4'b0111, 7'b000_0001, 7'b000_0001, 1'b1);

    skip(3);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
